// File: rtl/l6_pkg.sv
// ============================================================================
// l6_pkg : shared types and constants for the lab-6 fetch stage
// Rev 1.0
// ============================================================================
`default_nettype none

package l6_pkg;

  localparam int L6_PC_W = 16;
  localparam logic [L6_PC_W-1:0] L6_NOP = 16'h0000;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/l6_fetch_skid.sv
// ============================================================================
// l6_fetch_skid : one-entry instruction/PC holding buffer for stalled fetches
// Rev 1.0
// ============================================================================
`default_nettype none

module l6_fetch_skid
  import l6_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               clear,
  input  logic [L6_PC_W-1:0] d_instr,
  input  logic [L6_PC_W-1:0] d_pc,
  output logic               full,
  output logic [L6_PC_W-1:0] q_instr,
  output logic [L6_PC_W-1:0] q_pc
);

  logic               full_q, full_d;
  logic [L6_PC_W-1:0] instr_q, instr_d;
  logic [L6_PC_W-1:0] pc_q, pc_d;

  // Push wins over pop so a simultaneous drain-and-refill keeps the entry full.
  always_comb begin
    full_d  = full_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear) begin
      full_d = 1'b0;
    end else if (push) begin
      full_d  = 1'b1;
      instr_d = d_instr;
      pc_d    = d_pc;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q  <= 1'b0;
      instr_q <= L6_NOP;
      pc_q    <= '0;
    end else begin
      full_q  <= full_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign full    = full_q;
  assign q_instr = instr_q;
  assign q_pc    = pc_q;

endmodule

`default_nettype wire

// File: rtl/l6_fetch_pc.sv
// ============================================================================
// l6_fetch_pc : PC register, instruction-fetch sequencer and IF/ID register.
// Optional L6_FETCH_PERF_EN adds saturating branch/stall cycle counters.
// Rev 1.0
// ============================================================================
`default_nettype none

module l6_fetch_pc
  import l6_pkg::*;
#(
  parameter logic [L6_PC_W-1:0] RESET_PC = 16'h0000,
  parameter logic [L6_PC_W-1:0] PC_STEP  = 16'd1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               branch,
  input  logic [L6_PC_W-1:0] branch_target,
  input  logic               stall,
  output logic               imem_req,
  output logic [L6_PC_W-1:0] imem_addr,
  input  logic               imem_ready,
  input  logic [L6_PC_W-1:0] imem_data,
  output logic               if_valid,
  output logic [L6_PC_W-1:0] if_instr,
  output logic [L6_PC_W-1:0] if_pc,
  output logic               flush
`ifdef L6_FETCH_PERF_EN
  ,
  output logic [15:0]        perf_branches,
  output logic [15:0]        perf_stalls
`endif
);

  fetch_state_e       state_q, state_d;
  logic [L6_PC_W-1:0] pc_q, pc_d;
  logic [L6_PC_W-1:0] redir_q, redir_d;
  logic               pend_q, pend_d;
  logic               if_valid_q, if_valid_d;
  logic [L6_PC_W-1:0] if_instr_q, if_instr_d;
  logic [L6_PC_W-1:0] if_pc_q, if_pc_d;

  logic               req, fire, accept;
  logic               skid_push, skid_pop, skid_clear, skid_full;
  logic [L6_PC_W-1:0] skid_instr, skid_pc;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redir_d    = redir_q;
    pend_d     = pend_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    skid_push  = 1'b0;
    skid_pop   = 1'b0;
    skid_clear = 1'b0;
    accept     = 1'b0;

    case (state_q)
      S_FETCH: req = !(stall && skid_full);
      S_WAIT:  req = 1'b1;
      default: req = 1'b0;
    endcase
    fire = req && imem_ready;

    if (branch) begin
      skid_clear = 1'b1;
      if_valid_d = 1'b0;
      if_instr_d = L6_NOP;
      // An in-flight WAIT request must complete before the redirect can issue.
      if (state_q == S_WAIT && !imem_ready) begin
        redir_d = branch_target;
        pend_d  = 1'b1;
      end else begin
        pc_d    = branch_target;
        pend_d  = 1'b0;
        state_d = S_FETCH;
      end
    end else begin
      accept = fire && !pend_q;
      if (state_q == S_BOOT) begin
        state_d = S_FETCH;
      end else if (fire) begin
        state_d = S_FETCH;
        if (pend_q) begin
          pc_d   = redir_q;
          pend_d = 1'b0;
        end else begin
          pc_d = pc_q + PC_STEP;
        end
      end else if (req) begin
        state_d = S_WAIT;
      end

      if (stall) begin
        skid_push = accept;
      end else if (skid_full) begin
        // Buffered word goes first; a same-cycle fetch refills the buffer.
        if_valid_d = 1'b1;
        if_instr_d = skid_instr;
        if_pc_d    = skid_pc;
        skid_pop   = 1'b1;
        skid_push  = accept;
      end else if (accept) begin
        if_valid_d = 1'b1;
        if_instr_d = imem_data;
        if_pc_d    = pc_q;
      end else begin
        if_valid_d = 1'b0;
        if_instr_d = L6_NOP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      redir_q    <= '0;
      pend_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_instr_q <= L6_NOP;
      if_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redir_q    <= redir_d;
      pend_q     <= pend_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

  l6_fetch_skid u_skid (
    .clk     (clk),
    .rst     (rst),
    .push    (skid_push),
    .pop     (skid_pop),
    .clear   (skid_clear),
    .d_instr (imem_data),
    .d_pc    (pc_q),
    .full    (skid_full),
    .q_instr (skid_instr),
    .q_pc    (skid_pc)
  );

  assign imem_req  = req;
  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign flush     = branch;

`ifdef L6_FETCH_PERF_EN
  logic [15:0] perf_br_q, perf_br_d;
  logic [15:0] perf_st_q, perf_st_d;

  always_comb begin
    perf_br_d = perf_br_q;
    perf_st_d = perf_st_q;
    if (branch && perf_br_q != 16'hFFFF) perf_br_d = perf_br_q + 16'd1;
    if (stall && perf_st_q != 16'hFFFF)  perf_st_d = perf_st_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_br_q <= '0;
      perf_st_q <= '0;
    end else begin
      perf_br_q <= perf_br_d;
      perf_st_q <= perf_st_d;
    end
  end

  assign perf_branches = perf_br_q;
  assign perf_stalls   = perf_st_q;
`endif

endmodule

`default_nettype wire
